// File: rtl/char_uart_tx_pkg.sv
// Shared types and frame constants for the character UART transmitter.
// State codes are 4 bits wide so they can be mirrored directly onto a debug bus.
package char_uart_tx_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_START = 4'd1,
    ST_DATA  = 4'd2,
    ST_STOP  = 4'd3
  } tx_state_e;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  localparam int BIT_IDX_W = $clog2(DATA_BITS);

endpackage

// File: rtl/char_fifo.sv
// Synchronous character FIFO. A push when full and a pop when empty are ignored;
// full/empty come from the pre-edge count, so a full FIFO never accepts on a pop edge.
module char_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     wr_data,
  input  logic             pop,
  output logic [W-1:0]     rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];
  assign count   = cnt;

  // Storage is not reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      cnt <= cnt + 1'b1;
      else if (do_pop && !do_push) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/char_uart_tx.sv
// Buffered 8N1 UART transmitter: characters arrive over valid/ready into a FIFO
// and are shifted out LSB first on a registered tx line, back-to-back when queued.
module char_uart_tx
  import char_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_W        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [7:0]       in_char,
  output logic             in_ready,
  output logic             tx,
  output logic             busy,
  output logic [CNT_W-1:0] fifo_count,
  output logic [3:0]       tx_state
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0]    BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_IDX_W-1:0] DATA_LAST = BIT_IDX_W'(DATA_BITS - 1);
  localparam logic [BIT_IDX_W-1:0] STOP_LAST = BIT_IDX_W'(STOP_BITS - 1);

  tx_state_e            state, state_n;
  logic [BAUD_W-1:0]    baud_cnt, baud_n;
  logic [BIT_IDX_W-1:0] bit_idx, bit_n;
  logic [7:0]           shift_reg, shift_n;
  logic                 tx_reg, tx_n;

  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_head;
  logic       pop_ok;
  logic       bit_done;

  // Handshake: a character transfers on any rising edge where in_valid && in_ready;
  // in_ready depends only on FIFO fullness, never on in_valid.
  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready;

  char_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (in_char),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign pop_ok   = en && !fifo_empty;
  assign bit_done = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_n;
      bit_idx   <= bit_n;
      shift_reg <= shift_n;
      tx_reg    <= tx_n;
    end
  end

  always_comb begin
    state_n  = state;
    baud_n   = baud_cnt + 1'b1;
    bit_n    = bit_idx;
    shift_n  = shift_reg;
    tx_n     = tx_reg;
    fifo_pop = 1'b0;
    case (state)
      ST_IDLE: begin
        baud_n = '0;
        tx_n   = 1'b1;
        if (pop_ok) begin
          fifo_pop = 1'b1;
          shift_n  = fifo_head;
          state_n  = ST_START;
          tx_n     = 1'b0;
        end
      end
      ST_START: begin
        if (bit_done) begin
          state_n = ST_DATA;
          baud_n  = '0;
          bit_n   = '0;
          tx_n    = shift_reg[0];
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          baud_n = '0;
          if (bit_idx == DATA_LAST) begin
            state_n = ST_STOP;
            bit_n   = '0;
            tx_n    = 1'b1;
          end else begin
            bit_n   = bit_idx + 1'b1;
            shift_n = shift_reg >> 1;
            tx_n    = shift_reg[1];
          end
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          baud_n = '0;
          if (bit_idx != STOP_LAST) begin
            bit_n = bit_idx + 1'b1;
          end else if (pop_ok) begin
            // Next frame starts straight from the stop bit, no idle gap.
            fifo_pop = 1'b1;
            shift_n  = fifo_head;
            state_n  = ST_START;
            bit_n    = '0;
            tx_n     = 1'b0;
          end else begin
            state_n = ST_IDLE;
            bit_n   = '0;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        baud_n  = '0;
        bit_n   = '0;
        tx_n    = 1'b1;
      end
    endcase
  end

  assign tx       = tx_reg;
  assign tx_state = state;
  assign busy     = (state != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_char_uart_tx.sv
// Directed bench for char_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Inputs change and outputs are sampled on the falling edge.
module tb_char_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst;
  logic          en;
  logic          in_valid;
  logic [7:0]    in_char;
  logic          in_ready;
  logic          tx;
  logic          busy;
  logic [CW-1:0] fifo_count;
  logic [3:0]    tx_state;

  int n_checks = 0;
  int n_errors = 0;

  char_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .CNT_W        (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .in_valid   (in_valid),
    .in_char    (in_char),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .tx_state   (tx_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input int exp_cnt);
    check({tag, "_state"}, 32'(tx_state), 32'd0);
    check({tag, "_tx"}, 32'(tx), 32'd1);
    check({tag, "_cnt"}, 32'(fifo_count), exp_cnt);
  endtask

  // Called on the first sample after the START edge; returns on the first
  // sample after the frame ends. drop_at >= 0 lowers en at that sample.
  task automatic check_frame(input logic [7:0] c, input int exp_cnt, input int drop_at);
    logic [9:0] frame;
    frame = {1'b1, c, 1'b0};
    for (int j = 0; j < 10 * CPB; j++) begin
      if (j == 0) check($sformatf("frame_%02h_cnt", c), 32'(fifo_count), exp_cnt);
      if (j == drop_at) en = 1'b0;
      check($sformatf("frame_%02h_slot%0d", c, j), 32'(tx), 32'(frame[j / CPB]));
      tick();
    end
  endtask

  task automatic push(input logic [7:0] c);
    in_valid = 1'b1;
    in_char  = c;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0]  fill_vals [4];
    logic [9:0]  c3_frame;
    fill_vals = '{8'h55, 8'hAA, 8'h0F, 8'hF0};
    c3_frame  = {1'b1, 8'hC3, 1'b0};

    rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_char = 8'h00;
    tick(); tick();
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_cnt", 32'(fifo_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(tx_state), 32'd0);
    rst = 1'b0;
    tick();
    check_idle("post_rst", 0);

    // Single character 0x41: accepted at edge k, tx falls after k+1.
    en = 1'b1;
    push(8'h41);
    check_idle("single_k", 1);
    check("single_busy", 32'(busy), 32'd1);
    tick();
    check("single_start", 32'(tx_state), 32'd1);
    check_frame(8'h41, 0, -1);
    check_idle("single_end", 0);
    check("single_end_busy", 32'(busy), 32'd0);

    // Fill with en low; fifth character must be refused.
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fill_ready%0d", i), 32'(in_ready), 32'd1);
      check($sformatf("fill_cnt%0d", i), 32'(fifo_count), i);
      in_valid = 1'b1;
      in_char  = fill_vals[i];
      tick();
    end
    in_char = 8'h33;
    check("full_ready", 32'(in_ready), 32'd0);
    check("full_cnt", 32'(fifo_count), 32'd4);
    tick(); tick();
    in_valid = 1'b0;
    check("full_hold_cnt", 32'(fifo_count), 32'd4);
    check("full_hold_ready", 32'(in_ready), 32'd0);
    check_idle("full_hold", 4);

    // Back-to-back drain: 160 contiguous slots, then idle.
    en = 1'b1;
    tick();
    check("b2b_start", 32'(tx_state), 32'd1);
    for (int i = 0; i < 4; i++) check_frame(fill_vals[i], 3 - i, -1);
    check_idle("b2b_end", 0);
    check("b2b_busy", 32'(busy), 32'd0);

    // Mid-frame reset during bit 3 of 0xC3 with two more queued.
    en = 1'b0;
    push(8'hC3);
    push(8'h11);
    push(8'h22);
    en = 1'b1;
    tick();
    check("mrst_start", 32'(tx_state), 32'd1);
    check("mrst_cnt", 32'(fifo_count), 32'd2);
    for (int j = 0; j < 17; j++) begin
      check($sformatf("mrst_slot%0d", j), 32'(tx), 32'(c3_frame[j / CPB]));
      tick();
    end
    check("mrst_bit3", 32'(tx), 32'd0);
    check("mrst_data", 32'(tx_state), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("mrst_after", 0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_ready", 32'(in_ready), 32'd1);
    for (int j = 0; j < 12; j++) begin
      tick();
      check($sformatf("mrst_quiet_tx%0d", j), 32'(tx), 32'd1);
    end
    check_idle("mrst_quiet", 0);

    // Simultaneous push/pop, then en dropped in DATA.
    in_valid = 1'b1;
    in_char  = 8'h5A;
    tick();
    check("drop_cnt_k", 32'(fifo_count), 32'd1);
    in_char = 8'h96;
    tick();
    in_valid = 1'b0;
    check("drop_pushpop_cnt", 32'(fifo_count), 32'd1);
    check("drop_start", 32'(tx_state), 32'd1);
    check_frame(8'h5A, 1, 2 * CPB);
    check_idle("drop_end", 1);
    repeat (5) tick();
    check_idle("drop_wait", 1);
    check("drop_busy", 32'(busy), 32'd1);
    en = 1'b1;
    tick();
    check("reen_start", 32'(tx_state), 32'd1);
    check_frame(8'h96, 0, -1);
    check_idle("reen_end", 0);
    check("reen_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/char_uart_tx.md
Name: char_uart_tx

Overview:
- Downstream consumer of the character stream produced by the experiment top-level.
- Accepts 8-bit characters over a valid/ready handshake and buffers them in a small FIFO.
- Serializes each character as UART 8N1, LSB first, on a single registered `tx` line.
- Exposes FIFO occupancy and FSM state so the top-level can mirror them onto debug outputs, alongside `chars_remaining` and `which_state`.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per UART bit. Must be ≥ 2.
- FIFO_DEPTH, 4: character buffer entries. Power of two, ≥ 2.
- CNT_W, $clog2(FIFO_DEPTH+1): width of `fifo_count`.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  transmit enable. When low, no new frame starts; a frame in flight completes.
- in_valid  in  1  upstream character valid.
- in_char  in  8  upstream character.
- in_ready  out  1  FIFO can accept a character. Combinational: high when the FIFO is not full.
- tx  out  1  UART serial output, registered. Idle level is 1.
- busy  out  1  high while the FSM is not IDLE, or while the FIFO is non-empty.
- fifo_count  out  CNT_W  number of buffered characters, 0..FIFO_DEPTH.
- tx_state  out  4  FSM state code: IDLE=0, START=1, DATA=2, STOP=3.

Behaviour:
- Reset values (sampled synchronously on `rst`=1):
  - tx=1, state=IDLE, fifo_count=0, FIFO pointers=0, bit counter=0, baud counter=0, busy=0.
  - in_ready=1 in the cycle after reset.
- Push: on a clock edge where in_valid && in_ready, write in_char at the write pointer.
  - The pointer wraps modulo FIFO_DEPTH and fifo_count increments.
  - When full, in_ready=0 and in_valid is ignored. Data is never overwritten.
- Pop: occurs only in IDLE, or at the end of STOP, when fifo_count>0 and en=1.
  - The head entry is loaded into the shift register.
  - The read pointer wraps and fifo_count decrements.
- Simultaneous push and pop on a non-full FIFO: fifo_count is unchanged and both pointers advance.
  - The full check uses the pre-edge count, so no push occurs when full even if a pop happens on the same edge.
- FSM:
  - IDLE: tx=1. When a pop is possible, pop and go to START. tx=0 from the next edge.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0. tx=shift[0].
  - DATA: each bit is held CLKS_PER_BIT cycles, then the register shifts right. After bit 7, go to STOP with tx=1.
  - STOP: hold tx=1 for CLKS_PER_BIT cycles. At expiry:
    - if a pop is possible, go straight to START (back-to-back frames, no idle gap);
    - otherwise go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 within each bit and reloads to 0 on every state or bit transition.
  - Bit expiry is when the counter equals CLKS_PER_BIT-1.
- Latency:
  - Character accepted at edge k with the FIFO empty and the FSM idle:
    - fifo_count=1 after edge k;
    - pop at edge k+1, so tx falls after edge k+1 and fifo_count returns to 0.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
- en deasserted mid-frame: the current frame finishes, then the FSM goes to IDLE. Pushes are still accepted while en=0.
- rst asserted mid-frame: all state returns to reset values at that edge, and tx=1 the following cycle. Buffered characters are discarded.
- busy = (state!=IDLE) || (fifo_count!=0).

Decomposition:
- Shared package holds the state enum (IDLE/START/DATA/STOP as 4-bit codes, matching the top-level `which_state` width) and the UART frame constants (DATA_BITS=8, STOP_BITS=1).
- One natural sub-module: char_fifo, a synchronous FIFO with push/pop/full/empty/count ports. The FSM and baud logic stay in char_uart_tx.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset check: hold rst 2 cycles, then release.
  - → tx=1, in_ready=1, fifo_count=0, busy=0, tx_state=0.
- Single char: push 0x41 at edge k.
  - → tx falls after edge k+1.
  - → bits 1,0,0,0,0,0,1,0 in 4-cycle slots, then stop=1.
  - → tx_state returns to 0 after 40 cycles.
- Fill: push 0x55,0xAA,0x0F,0xF0,0x33 on consecutive cycles with en=0.
  - → in_ready=0 after the 4th push and fifo_count=4.
  - → 0x33 is rejected (in_valid held, no write).
- Back-to-back: set en=1 with 4 chars buffered.
  - → 4 frames, 160 cycles total, no idle cycle between the stop bit and the next start bit.
  - → fifo_count decrements 4→0.
- Mid-frame reset: assert rst during bit 3 of 0xC3 with 2 chars queued.
  - → next cycle tx=1, fifo_count=0, tx_state=0, and no further frames.
- en drop: deassert en during the DATA phase.
  - → the frame completes, the FSM stays in IDLE with fifo_count unchanged.
  - → re-asserting en starts the next frame one edge later.
